// File: rtl/nor3_idle_pkg.sv
// Shared types and reset constants for the three-input NOR idle filter.
package nor3_idle_pkg;

   typedef enum logic {
      STABLE = 1'b0,
      QUAL   = 1'b1
   } state_e;

   localparam logic Y_RST    = 1'b1;
   localparam logic SYNC_RST = 1'b0;

endpackage

// File: rtl/sync_chain.sv
// WIDTH-bit multi-flop synchroniser; every flop clears to SYNC_RST on async reset.
module sync_chain
   import nor3_idle_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] chain_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain_q <= {STAGES{{WIDTH{SYNC_RST}}}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/nor3_idle_filter.sv
// Synchronised three-input NOR idle detect with a consecutive-sample glitch
// filter, registered idle flag and one-cycle edge pulses.
module nor3_idle_filter
   import nor3_idle_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic EN,
   output logic YRAW,
   output logic Y,
   output logic RISE,
   output logic FALL,
   output logic BUSY
);

   localparam int              CNT_W    = $clog2(FILT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [2:0]       sync_s;
   logic             raw;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             y_q;
   logic             rise_q;
   logic             fall_q;

   sync_chain #(
      .WIDTH  (3),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   ({A, B, C}),
      .q_o   (sync_s)
   );

   assign raw = ~|sync_s;

   // cnt_q holds the number of consecutive differing samples already seen.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         y_q     <= Y_RST;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            STABLE: begin
               if (EN && (raw != y_q)) begin
                  if (FILT_CYCLES == 1) begin
                     y_q    <= raw;
                     rise_q <= raw;
                     fall_q <= ~raw;
                  end else begin
                     cnt_q   <= CNT_ONE;
                     state_q <= QUAL;
                  end
               end
            end
            QUAL: begin
               if (!EN || (raw == y_q)) begin
                  cnt_q   <= '0;
                  state_q <= STABLE;
               end else if (cnt_q == CNT_LAST) begin
                  y_q     <= raw;
                  rise_q  <= raw;
                  fall_q  <= ~raw;
                  cnt_q   <= '0;
                  state_q <= STABLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= STABLE;
            end
         endcase
      end
   end

   assign YRAW = raw;
   assign Y    = y_q;
   assign RISE = rise_q;
   assign FALL = fall_q;
   assign BUSY = (state_q == QUAL);

endmodule

// File: tb/tb_nor3_idle_filter.sv
// Scoreboard bench: a run-length reference model predicts outputs after each
// edge; a negedge monitor pops and compares against the DUT.
module tb_nor3_idle_filter;

   localparam int S = 2;
   localparam int F = 4;

   typedef struct packed {
      logic yraw;
      logic y;
      logic rise;
      logic fall;
      logic busy;
   } exp_t;

   logic CLK = 1'b0;
   logic RST, A, B, C, EN;
   logic YRAW, Y, RISE, FALL, BUSY;

   int checks = 0;
   int errors = 0;
   int falls_seen = 0;

   exp_t exp_q[$];

   // reference model state
   logic [2:0] m_syn [S];
   logic       m_y;
   int         m_run;
   exp_t       m_out;

   nor3_idle_filter #(.SYNC_STAGES(S), .FILT_CYCLES(F)) dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .C(C), .EN(EN),
      .YRAW(YRAW), .Y(Y), .RISE(RISE), .FALL(FALL), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t reset_exp();
      exp_t e;
      e = '{yraw: 1'b1, y: 1'b1, rise: 1'b0, fall: 1'b0, busy: 1'b0};
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < S; i++) m_syn[i] = 3'b000;
      m_y   = 1'b1;
      m_run = 0;
      m_out = reset_exp();
   endtask

   // Filter rule: Y flips once F consecutive enabled samples of raw differ from Y.
   task automatic model_edge(input logic [2:0] abc, input logic en);
      logic raw;
      logic r, f;
      raw = ~|m_syn[S-1];
      r = 1'b0;
      f = 1'b0;
      if (en && (raw != m_y)) m_run++;
      else m_run = 0;
      if (m_run == F) begin
         m_y   = raw;
         r     = raw;
         f     = ~raw;
         m_run = 0;
      end
      for (int i = S - 1; i > 0; i--) m_syn[i] = m_syn[i-1];
      m_syn[0] = abc;
      m_out = '{yraw: ~|m_syn[S-1], y: m_y, rise: r, fall: f, busy: (m_run > 0)};
   endtask

   task automatic check(input string name, input exp_t act, input exp_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got yraw/y/rise/fall/busy=%b expected %b",
                  name, $time, act, req);
      end
   endtask

   // Drive one cycle of inputs; called just after a rising edge.
   task automatic step(input logic [2:0] abc, input logic en);
      {A, B, C} = abc;
      EN = en;
      @(posedge CLK);
      if (!RST) model_edge(abc, en);
      exp_q.push_back(m_out);
      #1;
   endtask

   task automatic hold(input logic [2:0] abc, input logic en, input int n);
      for (int i = 0; i < n; i++) step(abc, en);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic reset_pulse(input int cycles);
      #2;
      RST = 1'b1;
      model_reset();
      exp_q.delete();
      exp_q.push_back(m_out);
      #1;
      check("async_reset", {YRAW, Y, RISE, FALL, BUSY}, reset_exp());
      for (int i = 0; i < cycles; i++) step({A, B, C}, EN);
      RST = 1'b0;
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("outputs", {YRAW, Y, RISE, FALL, BUSY}, e);
      end
      if (RISE && FALL) begin
         checks++;
         errors++;
         $display("FAIL pulse_excl at %0t: got RISE=1 FALL=1 expected not both", $time);
      end
      if (FALL) falls_seen++;
   end

   initial begin
      logic [2:0] cur;
      int         f0;
      RST = 1'b1; A = 1'b0; B = 1'b0; C = 1'b0; EN = 1'b1;
      model_reset();
      #3;
      check("reset_t0", {YRAW, Y, RISE, FALL, BUSY}, reset_exp());
      @(posedge CLK); #1;
      RST = 1'b0;
      hold(3'b000, 1'b1, 3);

      // A held: FALL on edge 6
      hold(3'b100, 1'b1, 8);
      hold(3'b000, 1'b1, 8);

      // A high 3 cycles: rejected; 4 cycles: accepted
      f0 = falls_seen;
      hold(3'b100, 1'b1, 3);
      hold(3'b000, 1'b1, 8);
      checks++;
      if (falls_seen != f0) begin
         errors++;
         $display("FAIL short_pulse: got %0d falls expected 0", falls_seen - f0);
      end
      hold(3'b100, 1'b1, 4);
      hold(3'b000, 1'b1, 10);

      // B glitch restarts the count
      step(3'b010, 1'b1); step(3'b010, 1'b1); step(3'b000, 1'b1);
      hold(3'b010, 1'b1, 8);
      hold(3'b000, 1'b1, 8);

      // EN drop during qualification, release with EN=0, then resume
      hold(3'b001, 1'b1, 4);
      hold(3'b001, 1'b0, 3);
      hold(3'b001, 1'b1, 8);
      hold(3'b000, 1'b0, 6);
      hold(3'b000, 1'b1, 8);

      // Reset at cnt=3 with A held
      hold(3'b100, 1'b1, 5);
      reset_pulse(2);
      hold(3'b100, 1'b1, 8);
      hold(3'b000, 1'b1, 8);

      // Randomised traffic
      cur = 3'b000;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(3, 0) == 0)
            cur = ($urandom_range(1, 0) == 0) ? 3'b000 : 3'($urandom_range(7, 0));
         step(cur, ($urandom_range(7, 0) != 0));
         if ($urandom_range(149, 0) == 0) reset_pulse($urandom_range(3, 0));
      end

      hold(3'b000, 1'b1, 2);
      @(negedge CLK); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
